via6522: RTL and testbench

Reduced MOS 6522 VIA occupying the 0xB8xx decode window (`via_cs`, address[15:10] == 6'b101110) and supplying the CPU read-data mux in place of the fixed 0xB1 constant. It provides:
- two 8-bit bidirectional ports with data-direction registers;
- Timer 1 (one-shot or free-run) and Timer 2 (one-shot);
- CA1 edge detection;
- the IFR/IER interrupt structure with an active-low IRQ output.

It runs on the CPU clock and is accessed exactly like the SPI peripheral.

---
 rtl/via6522_if.sv | 19 +
 rtl/via6522.sv | 199 +++++++++++++++++++
 tb/tb_via6522.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/via6522_if.sv
// via6522 CPU bus bundle: chip select, direction,
// register select, write data and combinational read data.
interface via6522_if;
  logic       enable;
  logic       rnw;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (
    output enable, rnw, addr, din,
    input  dout
  );

  modport slave (
    input  enable, rnw, addr, din,
    output dout
  );
endinterface

// File: rtl/via6522.sv
// Reduced 6522 VIA: two ports with DDRs, T1 (one-shot or
// free-run), T2 (one-shot), CA1 edge flag, IFR/IER and IRQ.
// Ports: clk, reset (sync, high); bus (via6522_if.slave:
// enable, rnw, addr, din, dout); pa_in/pb_in pin inputs;
// pa_out/pb_out, pa_oe/pb_oe port drive; ca1; irq_n.
// Optional VIA_PB7_EN: ACR[7] routes the T1 PB7 flop to pb7.
module via6522 (
  input  logic       clk,
  input  logic       reset,
  via6522_if.slave   bus,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe,
  input  logic       ca1,
  output logic       irq_n
);

  logic [7:0]  orb, ora, ddrb, ddra;
  logic [7:0]  t1l_lo, t1l_hi, t2l_lo;
  logic [7:0]  acr, pcr;
  logic [6:0]  ier;
  logic [15:0] t1_cnt, t2_cnt;
  logic        t1_armed, t1_reload, t2_armed;
  logic        f_t1, f_t2, f_ca1;
  logic        ca1_prev;
  logic        pb7;

  logic        wr, rd;
  logic [15:0] sel;
  logic        t1_wr_h, t1_zero, t1_uf, t1_clr;
  logic        t2_wr_h, t2_zero, t2_uf, t2_clr;
  logic        ca1_edge, ca1_clr;
  logic [6:0]  flags;
  logic [7:0]  ifr_val;
  logic [7:0]  dout_c;

  assign wr  = bus.enable & ~bus.rnw;
  assign rd  = bus.enable & bus.rnw;
  assign sel = 16'd1 << bus.addr;

  // A counter write on the same edge as an underflow wins:
  // the underflow is suppressed and the write clears the flag.
  assign t1_wr_h = wr & sel[5];
  assign t1_zero = (t1_cnt == 16'h0000);
  assign t1_uf   = t1_zero & t1_armed & ~t1_wr_h;
  assign t1_clr  = (rd & sel[4])
                 | (wr & (sel[5] | sel[7]))
                 | (wr & sel[13] & bus.din[6]);

  assign t2_wr_h = wr & sel[9];
  assign t2_zero = (t2_cnt == 16'h0000);
  assign t2_uf   = t2_zero & t2_armed & ~t2_wr_h;
  assign t2_clr  = (rd & sel[8])
                 | (wr & sel[9])
                 | (wr & sel[13] & bus.din[5]);

  assign ca1_edge = pcr[0] ? (ca1 & ~ca1_prev)
                           : (~ca1 & ca1_prev);
  assign ca1_clr  = (bus.enable & sel[1])
                  | (wr & sel[13] & bus.din[1]);

  assign flags   = {f_t1, f_t2, 3'b000, f_ca1, 1'b0};
  assign ifr_val = {|(flags & ier), flags};
  assign irq_n   = ~ifr_val[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      orb    <= 8'h00;
      ora    <= 8'h00;
      ddrb   <= 8'h00;
      ddra   <= 8'h00;
      t1l_lo <= 8'h00;
      t1l_hi <= 8'h00;
      t2l_lo <= 8'h00;
      acr    <= 8'h00;
      pcr    <= 8'h00;
      ier    <= 7'h00;
    end else if (wr) begin
      unique case (1'b1)
        sel[0]:          orb    <= bus.din;
        sel[1], sel[15]: ora    <= bus.din;
        sel[2]:          ddrb   <= bus.din;
        sel[3]:          ddra   <= bus.din;
        sel[4], sel[6]:  t1l_lo <= bus.din;
        sel[5], sel[7]:  t1l_hi <= bus.din;
        sel[8]:          t2l_lo <= bus.din;
        sel[11]:         acr    <= bus.din;
        sel[12]:         pcr    <= bus.din;
        sel[14]: begin
          if (bus.din[7]) ier <= ier | bus.din[6:0];
          else            ier <= ier & ~bus.din[6:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t1_cnt    <= 16'hFFFF;
      t1_armed  <= 1'b0;
      t1_reload <= 1'b0;
    end else if (t1_wr_h) begin
      t1_cnt    <= {bus.din, t1l_lo};
      t1_armed  <= 1'b1;
      t1_reload <= 1'b0;
    end else if (t1_zero) begin
      // Wrap for one cycle, then reload from the latch.
      t1_cnt <= 16'hFFFF;
      if (!acr[6]) t1_armed <= 1'b0;
      if (acr[6])  t1_reload <= 1'b1;
    end else if (t1_reload) begin
      t1_cnt    <= {t1l_hi, t1l_lo};
      t1_reload <= 1'b0;
    end else begin
      t1_cnt <= t1_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t2_cnt   <= 16'hFFFF;
      t2_armed <= 1'b0;
    end else if (t2_wr_h) begin
      t2_cnt   <= {bus.din, t2l_lo};
      t2_armed <= 1'b1;
    end else if (t2_zero) begin
      t2_cnt   <= 16'hFFFF;
      t2_armed <= 1'b0;
    end else begin
      t2_cnt <= t2_cnt - 16'd1;
    end
  end

  // A flag set on the same edge as its clear survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_t1     <= 1'b0;
      f_t2     <= 1'b0;
      f_ca1    <= 1'b0;
      ca1_prev <= 1'b0;
    end else begin
      f_t1     <= t1_uf | (f_t1 & ~t1_clr);
      f_t2     <= t2_uf | (f_t2 & ~t2_clr);
      f_ca1    <= ca1_edge | (f_ca1 & ~ca1_clr);
      ca1_prev <= ca1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pb7 <= 1'b1;
    end else if (t1_wr_h) begin
      pb7 <= 1'b0;
    end else if (t1_uf) begin
      pb7 <= acr[6] ? ~pb7 : 1'b1;
    end
  end

  assign pa_out = ora;
  assign pa_oe  = ddra;

`ifdef VIA_PB7_EN
  assign pb_out = acr[7] ? {pb7, orb[6:0]} : orb;
  assign pb_oe  = acr[7] ? {1'b1, ddrb[6:0]} : ddrb;
`else
  assign pb_out = orb;
  assign pb_oe  = ddrb;
  logic unused_pb7;
  assign unused_pb7 = pb7;
`endif

  always_comb begin
    dout_c = 8'h00;
    unique case (1'b1)
      sel[0]:          dout_c = (orb & ddrb) | (pb_in & ~ddrb);
      sel[1], sel[15]: dout_c = (ora & ddra) | (pa_in & ~ddra);
      sel[2]:          dout_c = ddrb;
      sel[3]:          dout_c = ddra;
      sel[4]:          dout_c = t1_cnt[7:0];
      sel[5]:          dout_c = t1_cnt[15:8];
      sel[6]:          dout_c = t1l_lo;
      sel[7]:          dout_c = t1l_hi;
      sel[8]:          dout_c = t2_cnt[7:0];
      sel[9]:          dout_c = t2_cnt[15:8];
      sel[11]:         dout_c = acr;
      sel[12]:         dout_c = pcr;
      sel[13]:         dout_c = ifr_val;
      sel[14]:         dout_c = {1'b1, ier};
      default:         dout_c = 8'h00;
    endcase
  end

  assign bus.dout = dout_c;

endmodule

// File: tb/tb_via6522.sv
// Bench for via6522: arithmetic timer model plus
// directed vectors with literal expectations.
module tb_via6522;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] pa_in, pb_in;
  logic [7:0] pa_out, pa_oe, pb_out, pb_oe;
  logic       ca1, irq_n;

  via6522_if bus ();

  via6522 dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pa_in  (pa_in),
    .pb_in  (pb_in),
    .pa_out (pa_out),
    .pa_oe  (pa_oe),
    .pb_out (pb_out),
    .pb_oe  (pb_oe),
    .ca1    (ca1),
    .irq_n  (irq_n)
  );

  int n_run  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  logic [7:0] rst_tab [16] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00,
    8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00
  };

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state. Timers are described by (n, k): loaded value and
  // edges elapsed since the load; values follow from arithmetic.
  logic [7:0] m_ora, m_orb, m_ddra, m_ddrb, m_acr, m_pcr;
  logic [7:0] m_t1ll, m_t1lh, m_t2ll;
  logic [6:0] m_ier;
  bit         m_f6, m_f5, m_f1, m_ca1p;
  int         t1_n, t1_k, t2_n, t2_k;
  bit         t1_free, t1_live, t2_live;

  function automatic bit uf_at(int n, int k, bit free);
    if (k == n + 1) return 1'b1;
    return free && (k > n + 1) && (((k - n - 1) % (n + 2)) == 0);
  endfunction

  function automatic logic [15:0] tval(int n, int k, bit free);
    int p;
    if (k <= n) return 16'(n - k);
    if (!free) return 16'(65535 - (k - n - 1));
    p = (k - n - 1) % (n + 2);
    if (p == 0) return 16'hFFFF;
    return 16'(n - (p - 1));
  endfunction

  function automatic bit m_pb7();
    if (!t1_live) return 1'b1;
    if (t1_k < t1_n + 1) return 1'b0;
    if (!t1_free) return 1'b1;
    return ((1 + (t1_k - t1_n - 1) / (t1_n + 2)) % 2) == 1;
  endfunction

  function automatic logic [7:0] m_ifr();
    logic [6:0] f;
    f = {m_f6, m_f5, 3'b000, m_f1, 1'b0};
    return {|(f & m_ier), f};
  endfunction

  function automatic logic m_irqn();
    logic [7:0] v;
    v = m_ifr();
    return ~v[7];
  endfunction

  function automatic logic [7:0] m_pbout();
`ifdef VIA_PB7_EN
    if (m_acr[7]) return {m_pb7(), m_orb[6:0]};
`endif
    return m_orb;
  endfunction

  function automatic logic [7:0] m_pboe();
`ifdef VIA_PB7_EN
    if (m_acr[7]) return {1'b1, m_ddrb[6:0]};
`endif
    return m_ddrb;
  endfunction

  function automatic logic [7:0] m_read(logic [3:0] a);
    logic [15:0] v1, v2;
    v1 = tval(t1_n, t1_k, t1_free);
    v2 = tval(t2_n, t2_k, 1'b0);
    case (a)
      4'h0: return (m_orb & m_ddrb) | (pb_in & ~m_ddrb);
      4'h1: return (m_ora & m_ddra) | (pa_in & ~m_ddra);
      4'h2: return m_ddrb;
      4'h3: return m_ddra;
      4'h4: return v1[7:0];
      4'h5: return v1[15:8];
      4'h6: return m_t1ll;
      4'h7: return m_t1lh;
      4'h8: return v2[7:0];
      4'h9: return v2[15:8];
      4'hB: return m_acr;
      4'hC: return m_pcr;
      4'hD: return m_ifr();
      4'hE: return {1'b1, m_ier};
      4'hF: return (m_ora & m_ddra) | (pa_in & ~m_ddra);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    bit rd, wr, s6, s5, s1, c6, c5, c1;
    logic [3:0] a;
    logic [7:0] d;
    if (reset) begin
      {m_ora, m_orb, m_ddra, m_ddrb} = '0;
      {m_acr, m_pcr, m_t1ll, m_t1lh, m_t2ll} = '0;
      m_ier = '0;
      {m_f6, m_f5, m_f1, m_ca1p} = '0;
      t1_n = 65535; t1_k = 0; t1_free = 0; t1_live = 0;
      t2_n = 65535; t2_k = 0; t2_live = 0;
      return;
    end
    a  = bus.addr;
    d  = bus.din;
    rd = bus.enable && bus.rnw;
    wr = bus.enable && !bus.rnw;
    {s6, s5, s1, c6, c5, c1} = '0;
    if (wr && a == 4'h5) begin
      t1_n = int'({d, m_t1ll}); t1_k = 0;
      t1_live = 1; t1_free = m_acr[6];
      m_t1lh = d; c6 = 1;
    end else begin
      t1_k++;
      s6 = t1_live && uf_at(t1_n, t1_k, t1_free);
    end
    if (wr && a == 4'h9) begin
      t2_n = int'({d, m_t2ll}); t2_k = 0;
      t2_live = 1; c5 = 1;
    end else begin
      t2_k++;
      s5 = t2_live && uf_at(t2_n, t2_k, 1'b0);
    end
    if (rd && a == 4'h4) c6 = 1;
    if (wr && a == 4'h7) c6 = 1;
    if (rd && a == 4'h8) c5 = 1;
    if (bus.enable && a == 4'h1) c1 = 1;
    if (wr && a == 4'hD) begin
      c6 |= d[6]; c5 |= d[5]; c1 |= d[1];
    end
    s1 = m_pcr[0] ? (ca1 && !m_ca1p) : (!ca1 && m_ca1p);
    m_ca1p = ca1;
    m_f6 = s6 || (m_f6 && !c6);
    m_f5 = s5 || (m_f5 && !c5);
    m_f1 = s1 || (m_f1 && !c1);
    if (wr) begin
      case (a)
        4'h0: m_orb = d;
        4'h1, 4'hF: m_ora = d;
        4'h2: m_ddrb = d;
        4'h3: m_ddra = d;
        4'h4, 4'h6: m_t1ll = d;
        4'h7: m_t1lh = d;
        4'h8: m_t2ll = d;
        4'hB: m_acr = d;
        4'hC: m_pcr = d;
        4'hE: m_ier = d[7] ? (m_ier | d[6:0]) : (m_ier & ~d[6:0]);
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk8("dout", bus.dout, m_read(bus.addr));
      chk1("irq_n", irq_n, m_irqn());
      chk8("pa_out", pa_out, m_ora);
      chk8("pa_oe", pa_oe, m_ddra);
      chk8("pb_out", pb_out, m_pbout());
      chk8("pb_oe", pb_oe, m_pboe());
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.enable = 1'b1; bus.rnw = 1'b0;
    bus.addr = a; bus.din = d;
    cyc();
    bus.enable = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.enable = 1'b1; bus.rnw = 1'b1; bus.addr = a;
    cyc();
    bus.enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.rnw = 1'b1;
    bus.addr = 4'h0; bus.din = 8'h00;
    pa_in = 8'h00; pb_in = 8'h00; ca1 = 1'b0;
    cyc();
    chk_on = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.addr = 4'(i);
      cyc();
      chk8("rst_reg", bus.dout, rst_tab[i]);
    end
    chk1("rst_irq", irq_n, 1'b1);
    reset = 1'b0;

    wr(4'h3, 8'hF0);
    wr(4'h1, 8'hA5);
    pa_in = 8'h3C;
    rd(4'h1);
    chk8("ira", bus.dout, 8'hAC);
    chk8("pa_oe_lit", pa_oe, 8'hF0);
    wr(4'h2, 8'h0F);
    wr(4'h0, 8'h5A);
    pb_in = 8'hC3;
    bus.addr = 4'h0;
    #1;
    chk8("irb", bus.dout, 8'hCA);

    wr(4'hE, 8'hC0);
    wr(4'h6, 8'h05);
    wr(4'h5, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk1("t1_oneshot", irq_n, (k >= 6) ? 1'b0 : 1'b1);
    end
    rd(4'h4);
    chk1("t1_rd_clr", irq_n, 1'b1);

    wr(4'hB, 8'h40);
    wr(4'h6, 8'h03);
    wr(4'h5, 8'h00);
    bus.addr = 4'hD; bus.din = 8'h40; bus.rnw = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      bus.enable = (k == 5 || k == 10 || k == 15);
      cyc();
      chk1("t1_free", bus.dout[6], (k == 4 || k == 9 || k == 14));
    end
    bus.enable = 1'b0;

    repeat (2) cyc();
    do_reset();
    bus.addr = 4'hD;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk1("rst_mid_irq", irq_n, 1'b1);
      chk8("rst_mid_ifr", bus.dout, 8'h00);
    end

    wr(4'hE, 8'hA0);
    wr(4'h8, 8'h02);
    wr(4'h9, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk1("t2_oneshot", irq_n, (k >= 3) ? 1'b0 : 1'b1);
    end
    rd(4'h8);
    chk1("t2_rd_clr", irq_n, 1'b1);
    repeat (6) cyc();
    chk1("t2_no_rearm", irq_n, 1'b1);

    wr(4'h9, 8'h00);
    cyc(); cyc();
    wr(4'h9, 8'h00);
    chk1("t2_wr_wins", irq_n, 1'b1);
    cyc(); cyc();
    chk1("t2_wr_wins2", irq_n, 1'b1);
    cyc();
    chk1("t2_after_rewr", irq_n, 1'b0);

    wr(4'h9, 8'h00);
    cyc(); cyc();
    rd(4'h8);
    chk1("t2_set_wins", irq_n, 1'b0);
    rd(4'h8);
    chk1("t2_clr_after", irq_n, 1'b1);

    do_reset();
    wr(4'hC, 8'h01);
    wr(4'hE, 8'h82);
    bus.addr = 4'hE;
    #1;
    chk8("ier_rd", bus.dout, 8'h82);
    bus.addr = 4'hD;
    ca1 = 1'b1;
    cyc();
    chk8("ca1_rise", bus.dout, 8'h82);
    chk1("ca1_irq", irq_n, 1'b0);
    rd(4'hF);
    bus.addr = 4'hD;
    #1;
    chk8("regF_noclr", bus.dout, 8'h82);
    rd(4'h1);
    bus.addr = 4'hD;
    #1;
    chk8("reg1_clr", bus.dout, 8'h00);
    chk1("reg1_irq", irq_n, 1'b1);
    wr(4'hC, 8'h00);
    ca1 = 1'b0;
    cyc();
    bus.addr = 4'hD;
    #1;
    chk8("ca1_fall", bus.dout, 8'h82);
    wr(4'hD, 8'h02);
    chk8("ifr_wr_clr", bus.dout, 8'h00);
    wr(4'hE, 8'h02);
    chk8("ier_clr", m_read(4'hE), 8'h80);
    bus.addr = 4'hE;
    #1;
    chk8("ier_clr_dut", bus.dout, 8'h80);

`ifdef VIA_PB7_EN
    do_reset();
    wr(4'hB, 8'hC0);
    chk1("pb7_rst", pb_out[7], 1'b1);
    chk1("pb7_oe", pb_oe[7], 1'b1);
    wr(4'h6, 8'h02);
    wr(4'h5, 8'h00);
    chk1("pb7_low", pb_out[7], 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk1("pb7_tog", pb_out[7], (k >= 3 && k < 7));
    end
    do_reset();
`endif

    for (int i = 0; i < 16; i++) begin
      bus.addr = 4'(i);
      cyc();
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
